boot_loader: RTL

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader_pkg.sv | 13 +
 rtl/boot_loader_if.sv | 31 +++
 rtl/boot_checksum.sv | 24 ++
 rtl/boot_loader.sv | 98 +++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared processor definitions for the boot loader: default bus widths and FSM state encoding.
package boot_loader_pkg;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } boot_state_t;

endpackage

// File: rtl/boot_loader_if.sv
// BIOS ROM read port and instruction-RAM write port; master is the loader, slave is the memory side.
interface boot_loader_if
   import boot_loader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic [ADDR_W-1:0] bios_address;
   logic [DATA_W-1:0] bios_instruction;
   logic              mem_write_enable;
   logic [ADDR_W-1:0] mem_write_address;
   logic [DATA_W-1:0] mem_write_data;

   modport master (
      output bios_address,
      input  bios_instruction,
      output mem_write_enable,
      output mem_write_address,
      output mem_write_data
   );

   modport slave (
      input  bios_address,
      output bios_instruction,
      input  mem_write_enable,
      input  mem_write_address,
      input  mem_write_data
   );

endinterface

// File: rtl/boot_checksum.sv
// Wrap-around sum of every word written to instruction RAM; clear wins over add.
module boot_checksum #(
   parameter int DATA_W = 32
) (
   input  logic              i_clock,
   input  logic              i_clear,
   input  logic              i_add_vld,
   input  logic [DATA_W-1:0] i_add_dat,
   output logic [DATA_W-1:0] o_sum
);

   logic [DATA_W-1:0] r_sum;

   always_ff @(posedge i_clock) begin
      if (i_clear) begin
         r_sum <= '0;
      end else if (i_add_vld) begin
         r_sum <= r_sum + i_add_dat;
      end
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/boot_loader.sv
// Copies BOOT_WORDS BIOS words into instruction RAM after reset or on start; one word per cycle,
// one-cycle read-to-write latency, processor stalled until the copy completes.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int BOOT_WORDS = 191
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   boot_loader_if.master     bus,
   output logic              o_cpu_stall,
   output logic              o_done,
   output logic [DATA_W-1:0] o_checksum
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BOOT_WORDS - 1);

   boot_state_t       r_state;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic              r_wr_vld;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_done;
   logic              r_cpu_stall;

   logic              w_restart;
   logic              w_write;

   assign w_restart = (r_state == ST_DONE) && i_start;
   // A write already staged is dropped in the same cycle reset is seen.
   assign w_write   = r_wr_vld && !i_reset;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= ST_LOAD;
         r_rd_ptr    <= '0;
         r_wr_vld    <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_done      <= 1'b0;
         r_cpu_stall <= 1'b1;
      end else begin
         case (r_state)
            ST_LOAD: begin
               r_wr_vld  <= 1'b1;
               r_wr_addr <= r_rd_ptr;
               r_wr_data <= bus.bios_instruction;
               // Parking the pointer at 0 keeps the ROM address at 0 outside LOAD and avoids a wrap.
               if (r_rd_ptr == LAST_ADDR) begin
                  r_rd_ptr <= '0;
                  r_state  <= ST_DRAIN;
               end else begin
                  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
               end
            end
            ST_DRAIN: begin
               r_wr_vld    <= 1'b0;
               r_state     <= ST_DONE;
               r_done      <= 1'b1;
               r_cpu_stall <= 1'b0;
            end
            ST_DONE: begin
               if (i_start) begin
                  r_state     <= ST_LOAD;
                  r_done      <= 1'b0;
                  r_cpu_stall <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_LOAD;
               r_rd_ptr <= '0;
               r_wr_vld <= 1'b0;
            end
         endcase
      end
   end

   boot_checksum #(
      .DATA_W (DATA_W)
   ) u_checksum (
      .i_clock   (i_clock),
      .i_clear   (i_reset || w_restart),
      .i_add_vld (w_write),
      .i_add_dat (r_wr_data),
      .o_sum     (o_checksum)
   );

   assign bus.bios_address      = r_rd_ptr;
   assign bus.mem_write_enable  = w_write;
   assign bus.mem_write_address = r_wr_addr;
   assign bus.mem_write_data    = r_wr_data;
   assign o_cpu_stall           = r_cpu_stall;
   assign o_done                = r_done;

endmodule
